// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and SRAM geometry for the external data memory controller.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} sram_state_t;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
    localparam int SRAM_DW = 16;
    localparam int DEF_SRAM_AW = 18;
endpackage

// File: rtl/sram_controller.sv
// sram_controller: services 32-bit loads/stores as two 16-bit SRAM half-accesses, freezing the pipeline via ready.
module sram_controller
    import mem_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
    parameter int          SRAM_AW       = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);
    localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);
    sram_state_t        state;
    logic [CW-1:0]      cnt;
    logic [SRAM_AW-2:0] idx;
    logic [SRAM_AW-2:0] req_idx;
    logic [15:0]        data_hi;
    logic [15:0]        lo_buf;
    logic               is_wr;
    logic               req;
    assign req     = rd_en | wr_en;
    assign req_idx = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);
    assign ready   = (state == DONE) || (state == IDLE && !req);
    // Strobes are registered alongside the state so they line up with LOW/HIGH cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            data_hi     <= '0;
            lo_buf      <= '0;
            is_wr       <= 1'b0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: if (req) begin
                    idx         <= req_idx;
                    data_hi     <= write_data[31:16];
                    is_wr       <= wr_en;
                    cnt         <= CNT_LOAD;
                    state       <= LOW;
                    sram_addr   <= {req_idx, 1'b0};
                    sram_dq_out <= write_data[15:0];
                    sram_dq_oe  <= wr_en;
                    sram_we_n   <= !wr_en;
                    sram_oe_n   <= wr_en;
                end
                LOW: if (cnt == '0) begin
                    cnt         <= CNT_LOAD;
                    state       <= HIGH;
                    sram_addr   <= {idx, 1'b1};
                    sram_dq_out <= data_hi;
                    if (!is_wr) lo_buf <= sram_dq_in;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                HIGH: if (cnt == '0) begin
                    state      <= DONE;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    // Published only on completion so read_data holds its old value mid-load.
                    if (!is_wr) read_data <= {sram_dq_in, lo_buf};
                end else begin
                    cnt <= cnt - CW'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed scoreboard bench driving the controller against a behavioural 16-bit SRAM.
module tb_sram_controller;
    logic        clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst, rd_en, wr_en, rd1, wr1;
    logic [31:0] address, write_data, read_data, read_data1;
    logic        ready, ready1;
    logic [17:0] sram_addr, sram_addr1;
    logic [15:0] sram_dq_out, sram_dq_out1, sram_dq_in;
    logic        sram_dq_oe, sram_dq_oe1, sram_we_n, sram_we_n1, sram_oe_n, sram_oe_n1;
    logic [15:0] mem [0:63] = '{default: 16'h0};
    logic [31:0] exp_q [$];
    int errors = 0;
    int checks = 0;
    int f, w, c, gap;

    sram_controller #(.ACCESS_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    sram_controller #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(address),
        .write_data(write_data), .read_data(read_data1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
        .sram_dq_in(16'h0), .sram_we_n(sram_we_n1), .sram_oe_n(sram_oe_n1)
    );

    always @(posedge clk) if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
    assign sram_dq_in = sram_oe_n ? 16'h0 : mem[sram_addr[5:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic r, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rd_en = r; wr_en = wr; address = a; write_data = d;
    endtask

    task automatic wait_done(input string tag, input bit is_load, output int frozen, output int we_low, output int clash);
        bit got = 0;
        logic [31:0] e;
        frozen = 0; we_low = 0; clash = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (!sram_we_n) we_low++;
            if (sram_dq_oe && !sram_oe_n) clash++;
            if (ready) got = 1;
            else frozen++;
        end
        chk({tag, "_ready_seen"}, 32'(got), 32'd1);
        if (is_load && got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_read_data"}, read_data, e);
        end
    endtask

    initial begin
        rst = 1'b0; rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024; write_data = '0;
        rd1 = 1'b0; wr1 = 1'b0;
        exp_q.push_back(32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_ready_with_req", 32'(ready), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("start_after_rst_oe_n", 32'(sram_oe_n), 32'd0);
        wait_done("first_load", 1, f, w, c);

        go(0, 1, 32'd1024, 32'hDEADBEEF);
        wait_done("store0", 0, f, w, c);
        chk("store0_frozen", 32'(f), 32'd5);
        chk("store0_we_low", 32'(w), 32'd4);
        chk("store0_clash", 32'(c), 32'd0);
        chk("store0_mem_lo", 32'(mem[0]), 32'h0000BEEF);
        chk("store0_mem_hi", 32'(mem[1]), 32'h0000DEAD);
        chk("store0_read_data_kept", read_data, 32'h0);

        exp_q.push_back(32'hDEADBEEF);
        go(1, 0, 32'd1024, 32'h0);
        wait_done("load0", 1, f, w, c);
        chk("load0_frozen", 32'(f), 32'd5);
        chk("load0_we_low", 32'(w), 32'd0);
        chk("load0_clash", 32'(c), 32'd0);

        go(1, 1, 32'd1028, 32'h12345678);
        wait_done("both", 0, f, w, c);
        chk("both_mem_lo", 32'(mem[2]), 32'h00005678);
        chk("both_mem_hi", 32'(mem[3]), 32'h00001234);
        chk("both_read_data_kept", read_data, 32'hDEADBEEF);

        exp_q.push_back(32'h0);
        go(1, 0, 32'd1032, 32'h0);
        wait_done("b2b_load", 1, f, w, c);
        go(0, 1, 32'd1036, 32'hA5A55A5A);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            gap++;
            if (!sram_we_n) break;
            @(negedge clk);
        end
        chk("b2b_gap", 32'(gap), 32'd3);
        wait_done("b2b_store", 0, f, w, c);
        chk("b2b_mem_lo", 32'(mem[6]), 32'h00005A5A);
        chk("b2b_mem_hi", 32'(mem[7]), 32'h0000A5A5);

        go(0, 1, 32'd1040, 32'h11112222);
        wait_done("pre_abort", 0, f, w, c);
        go(0, 1, 32'd1040, 32'hCAFEF00D);
        repeat (4) @(negedge clk);
        chk("abort_in_high_addr", 32'(sram_addr), 32'd9);
        #2 rst = 1'b0;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
        chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_sram_addr", 32'(sram_addr), 32'd0);
        chk("abort_read_data", read_data, 32'h0);
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk) rst = 1'b1;
        chk("abort_mem_hi_old", 32'(mem[9]), 32'h00001111);
        exp_q.push_back(32'h1111F00D);
        go(1, 0, 32'd1040, 32'h0);
        wait_done("abort_load", 1, f, w, c);
        go(0, 0, 32'd0, 32'h0);

        @(posedge clk);
        #1 wr1 = 1'b1; address = 32'd1044; write_data = 32'h0BADCAFE;
        f = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready1) break;
            f++;
        end
        chk("ac1_store_frozen", 32'(f), 32'd3);
        @(posedge clk);
        #1 wr1 = 1'b0; rd1 = 1'b1;
        f = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready1) break;
            f++;
        end
        chk("ac1_load_frozen", 32'(f), 32'd3);
        @(posedge clk);
        #1 rd1 = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
